// File: rtl/ladrao_round_gen.sv
// ladrao_round_gen: LFSR-driven thief pattern generator with timed rounds.
// Build option LADRAO_EARLY_END_EN: a catch ends the round right after the hit pulse.
module ladrao_round_gen #(
    parameter int          TICK_DIV    = 25000000,
    parameter int          ROUND_TICKS = 3,
    parameter logic [17:0] SEED        = 18'h2A5C3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [2:0]  level,
    input  logic [17:0] sw,
    output logic [17:0] thieves,
    output logic        hit,
    output logic        round_done,
    output logic        busy
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0] T_LAST = 4'(ROUND_TICKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_GEN, S_SHOW, S_END} state_e;

    state_e        state_q, state_d;
    logic [17:0]   lfsr_q, lfsr_d;
    logic [17:0]   thieves_q, thieves_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    tick_q, tick_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [2:0]    lvl_q, lvl_d;
    logic          caught_q, caught_d;
    logic          hit_q, hit_d;
    logic          done_q, done_d;
    logic [4:0]    idx;
    logic [17:0]   pick;
    logic          free;

    // x^18 + x^11 + 1, shifting toward the MSB
    assign lfsr_d = {lfsr_q[16:0], lfsr_q[17] ^ lfsr_q[10]};
    assign idx    = lfsr_q[4:0];
    assign pick   = 18'd1 << idx;
    assign free   = (idx < 5'd18) && ((thieves_q & pick) == 18'd0);

    always_comb begin
        state_d   = state_q;
        thieves_d = thieves_q;
        presc_d   = presc_q;
        tick_d    = tick_q;
        cnt_d     = cnt_q;
        lvl_d     = lvl_q;
        caught_d  = caught_q;
        hit_d     = 1'b0;
        done_d    = 1'b0;
        if (stop) begin
            state_d   = S_IDLE;
            thieves_d = '0;
            presc_d   = '0;
            tick_d    = '0;
            cnt_d     = '0;
            caught_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    thieves_d = '0;
                    if (start && level != 3'd0) begin
                        lvl_d    = (level > 3'd4) ? 3'd4 : level;
                        cnt_d    = '0;
                        caught_d = 1'b0;
                        state_d  = S_GEN;
                    end
                end
                S_GEN: begin
                    if (cnt_q == lvl_q) begin
                        presc_d = '0;
                        tick_d  = '0;
                        state_d = S_SHOW;
                    end else if (free) begin
                        thieves_d = thieves_q | pick;
                        cnt_d     = cnt_q + 3'd1;
                    end
                end
                S_SHOW: begin
                    if (sw == thieves_q && !caught_q) begin
                        hit_d    = 1'b1;
                        caught_d = 1'b1;
                    end
                    if (presc_q == P_LAST) begin
                        presc_d = '0;
                        tick_d  = tick_q + 4'd1;
                        if (tick_q == T_LAST) state_d = S_END;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
`ifdef LADRAO_EARLY_END_EN
                    if (caught_q) state_d = S_END;
`endif
                end
                S_END: begin
                    done_d    = 1'b1;
                    thieves_d = '0;
                    cnt_d     = '0;
                    caught_d  = 1'b0;
                    state_d   = S_GEN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            lfsr_q    <= SEED;
            thieves_q <= '0;
            presc_q   <= '0;
            tick_q    <= '0;
            cnt_q     <= '0;
            lvl_q     <= '0;
            caught_q  <= 1'b0;
            hit_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            thieves_q <= thieves_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            cnt_q     <= cnt_d;
            lvl_q     <= lvl_d;
            caught_q  <= caught_d;
            hit_q     <= hit_d;
            done_q    <= done_d;
        end
    end

    assign thieves    = thieves_q;
    assign hit        = hit_q;
    assign round_done = done_q;
    assign busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_ladrao_round_gen.sv
// tb_ladrao_round_gen: directed table plus hand sequences for ladrao_round_gen.
// Runs TICK_DIV=4, ROUND_TICKS=3; expectations adapt to LADRAO_EARLY_END_EN.
module tb_ladrao_round_gen;
    localparam logic [17:0] SEED_TB = 18'h2A5C3;
    localparam int W = 3;
    // Cycles from "pattern complete" sample to round_done: 1 GEN + 12 SHOW + 1 END
    localparam int GAP_FULL = 14;
`ifdef LADRAO_EARLY_END_EN
    localparam int GAP_HIT = 5;
`else
    localparam int GAP_HIT = 14;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [2:0]  level = 3'd0;
    logic [17:0] sw = '0;
    logic [17:0] thieves;
    logic        hit;
    logic        round_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] lv;
        bit         match;
        int         pop;
        int         hits;
        int         gap;
    } vec_t;

    vec_t vecs[6];

    ladrao_round_gen #(
        .TICK_DIV(4),
        .ROUND_TICKS(3),
        .SEED(SEED_TB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .stop(stop),
        .level(level),
        .sw(sw),
        .thieves(thieves),
        .hit(hit),
        .round_done(round_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({busy, hit, round_done, thieves});
    endfunction

    function automatic logic [17:0] model_first(input int k, input int lv);
        logic [17:0] l;
        logic [17:0] pat;
        int n;
        l = SEED_TB;
        for (int i = 0; i < k; i++) l = {l[16:0], l[17] ^ l[10]};
        pat = '0;
        n = 0;
        for (int i = 0; i < 10000 && n < lv; i++) begin
            if (l[4:0] < 5'd18 && pat[l[4:0]] == 1'b0) begin
                pat[l[4:0]] = 1'b1;
                n++;
            end
            l = {l[16:0], l[17] ^ l[10]};
        end
        return pat;
    endfunction

    task automatic wait_pop(input int lv, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if ($countones(thieves) == lv) ok = 1'b1;
            else step();
        end
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        sw    = '0;
        #1;
        step();
        chk({nm, "_rst_outs"}, outs(), 32'd0);
        step();
        rst_n = 1'b1;
    endtask

    task automatic capture(input int lv, output logic [17:0] pat);
        bit ok;
        start = 1'b1;
        level = 3'(lv);
        step();
        start = 1'b0;
        wait_pop(lv, ok);
        chk("cap_reached", 32'(ok), 32'd1);
        pat = thieves;
    endtask

    task automatic idle_stop();
        stop = 1'b1;
        sw = '0;
        step();
        stop = 1'b0;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int p, hits, hitpos, gap;
        bit both;
        logic [17:0] pat;
        p = -1; hits = 0; hitpos = -1; gap = -1; both = 1'b0; pat = '0;
        start = 1'b1;
        level = v.lv;
        step();
        start = 1'b0;
        level = 3'd1;
        for (int c = 0; c < 300 && gap < 0; c++) begin
            if (p < 0 && $countones(thieves) == v.pop) p = c;
            if (p >= 0 && c == p + 1) pat = thieves;
            if (v.match && p >= 0 && c == p + 2) sw = thieves;
            if (hit) begin
                hits++;
                if (hitpos < 0 && p >= 0) hitpos = c - p;
            end
            if (hit && round_done) both = 1'b1;
            if (round_done && p >= 0) gap = c - p;
            if (gap < 0) step();
        end
        chk($sformatf("v%0d_pop", id), 32'($countones(pat)), 32'(v.pop));
        chk($sformatf("v%0d_hits", id), 32'(hits), 32'(v.hits));
        chk($sformatf("v%0d_gap", id), 32'(gap), 32'(v.gap));
        chk($sformatf("v%0d_overlap", id), 32'(both), 32'd0);
        if (v.match) chk($sformatf("v%0d_hitpos", id), 32'(hitpos), 32'd3);
        idle_stop();
        chk($sformatf("v%0d_stop", id), outs(), 32'd0);
    endtask

    initial begin
        logic [17:0] pat_a, pat_b, cov;
        bit ok, seen;
        vecs[0] = '{3'd3, 1'b0, 3, 0, GAP_FULL};
        vecs[1] = '{3'd3, 1'b1, 3, 1, GAP_HIT};
        vecs[2] = '{3'd7, 1'b0, 4, 0, GAP_FULL};
        vecs[3] = '{3'd1, 1'b1, 1, 1, GAP_HIT};
        vecs[4] = '{3'd4, 1'b1, 4, 1, GAP_HIT};
        vecs[5] = '{3'd2, 1'b0, 2, 0, GAP_FULL};

        // Fresh run: first pattern is fixed by SEED and start timing
        do_reset("init");
        repeat (W) step();
        capture(3, pat_a);
        chk("first_pat_model", 32'(pat_a), 32'(model_first(W + 1, 3)));

        // Drop reset mid-SHOW, then repeat identical start timing
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs", outs(), 32'd0);
        do_reset("mid");
        repeat (W) step();
        capture(3, pat_b);
        chk("replay_pat", 32'(pat_b), 32'(pat_a));
        idle_stop();

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // level 0 is ignored
        seen = 1'b0;
        start = 1'b1;
        level = 3'd0;
        for (int i = 0; i < 6; i++) begin
            step();
            start = 1'b0;
            seen |= busy;
        end
        chk("lvl0_busy", 32'(seen), 32'd0);

        // stop in GEN
        start = 1'b1;
        level = 3'd4;
        step();
        start = 1'b0;
        chk("gen_busy", 32'(busy), 32'd1);
        idle_stop();
        chk("gen_stop", outs(), 32'd0);

        // stop in SHOW while sw matches: no hit may follow
        start = 1'b1;
        level = 3'd2;
        step();
        start = 1'b0;
        wait_pop(2, ok);
        chk("show_reached", 32'(ok), 32'd1);
        repeat (3) step();
        sw = thieves;
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("show_stop", outs(), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            seen |= (busy | hit | round_done);
        end
        chk("show_stop_quiet", 32'(seen), 32'd0);
        sw = '0;

        // 1000 rounds at level 4
        cov = '0;
        start = 1'b1;
        level = 3'd4;
        step();
        start = 1'b0;
        for (int r = 0; r < 1000; r++) begin
            wait_pop(4, ok);
            chk($sformatf("r%0d_pop4", r), 32'(ok), 32'd1);
            cov |= thieves;
            seen = 1'b0;
            for (int c = 0; c < 100 && !seen; c++) begin
                if (round_done) seen = 1'b1;
                else step();
            end
            chk($sformatf("r%0d_done", r), 32'(seen), 32'd1);
            step();
        end
        chk("coverage18", 32'(cov), 32'h3FFFF);
        idle_stop();
        chk("final_idle", outs(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
